// File: rtl/mem_pkg.sv
// Shared load/store constants and sequencer state encoding, also used by the Pmmu
// and by the decoder's early trap check.
package mem_pkg;

  localparam logic [1:0] BYTE_SIZE     = 2'b00;
  localparam logic [1:0] HALFWORD_SIZE = 2'b01;
  localparam logic [1:0] WORD_SIZE     = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/ls_align_check.sv
// Combinational load/store legality check: misaligned halfword/word accesses and
// funct3 encodings that have no load or store meaning.
module ls_align_check
  import mem_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  logic       is_store,
  output logic       fault
);

  logic [1:0] size;

  always_comb begin
    size  = funct3[1:0];
    fault = 1'b0;
    if (size == HALFWORD_SIZE && addr_lo[0])          fault = 1'b1;
    if (size == WORD_SIZE && addr_lo != 2'b00)        fault = 1'b1;
    if (size == 2'b11)                                fault = 1'b1;
    if (!is_store && funct3 == 3'b110)                fault = 1'b1;
    if (is_store && funct3[2])                        fault = 1'b1;
  end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer: latches one request and drives the Pmmu's active-low
// read/write strobes, using read-modify-write for sub-word stores.
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic [DATA_WIDTH-1:0] pmmu_addr_o,
  output logic [2:0]            pmmu_funct3_o,
  output logic [DATA_WIDTH-1:0] pmmu_wd_o,
  output logic                  pmmu_mrd_o,
  output logic                  pmmu_mwr_o,
  input  logic [DATA_WIDTH-1:0] pmmu_rd_i,
  input  logic                  pmmu_rdy_i
);

  seq_state_t            state, state_next;
  logic                  pending;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wd;
  logic [DATA_WIDTH-1:0] load_q;
  logic                  fault_q;
  logic                  live_fault;
  logic                  accept;
  logic                  sel_store;
  logic [2:0]            sel_funct3;
  logic                  word_store;

  ls_align_check u_align_check (
    .funct3   (funct3_i),
    .addr_lo  (addr_i[1:0]),
    .is_store (is_store_i),
    .fault    (live_fault)
  );

  // A request waiting for pmmu_rdy_i is routed from the latched copy, a fresh one from the inputs.
  always_comb begin
    accept     = (state == IDLE) && !pending && start_i;
    sel_store  = accept ? is_store_i : req_store;
    sel_funct3 = accept ? funct3_i : req_funct3;
    word_store = sel_store && (sel_funct3[1:0] == WORD_SIZE);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && live_fault) begin
          state_next = DONE;
        end else if ((accept || pending) && pmmu_rdy_i) begin
          state_next = word_store ? WRITE : RD_ADDR;
        end
      end
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = req_store ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= (state == IDLE) && (state_next == IDLE) && (pending || accept);
    end
  end

  // Request register and load result; the Pmmu only ever sees these, never the live inputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_store  <= 1'b0;
      req_funct3 <= 3'b000;
      req_addr   <= '0;
      req_wd     <= '0;
      fault_q    <= 1'b0;
      load_q     <= '0;
    end else begin
      if (accept) begin
        req_store  <= is_store_i;
        req_funct3 <= funct3_i;
        req_addr   <= addr_i;
        req_wd     <= wdata_i;
        fault_q    <= live_fault;
      end
      if (state == RD_DATA && !req_store) begin
        load_q <= pmmu_rd_i;
      end
    end
  end

  always_comb begin
    busy_o        = (state != IDLE) || pending;
    done_o        = (state == DONE);
    fault_o       = (state == DONE) && fault_q;
    pmmu_mrd_o    = !((state == RD_ADDR) || (state == RD_DATA));
    pmmu_mwr_o    = !(state == WRITE);
    load_data_o   = load_q;
    pmmu_addr_o   = req_addr;
    pmmu_funct3_o = req_funct3;
    pmmu_wd_o     = req_wd;
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Load/store sequencer between the control matrix and the Pmmu. It latches one load or store request and drives the Pmmu's active-low read/write strobes in the order the synchronous BRAM needs. Byte and halfword stores get a read-modify-write sequence, so the Pmmu's store-merge muxes see valid storage data. Alignment and funct3 faults are flagged before any memory strobe is driven, and loaded data is held in a register for writeback.

## Interface
- DATA_WIDTH, 32, data and address width.
- clk_i  in  1  clock, pos-edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request strobe; sampled only in IDLE.
- is_store_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  ir[14:12] of the load/store instruction.
- addr_i  in  DATA_WIDTH  byte address from the ALU.
- wdata_i  in  DATA_WIDTH  store data (rs2).
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- fault_o  out  1  valid only with done_o; 1 = request aborted.
- load_data_o  out  DATA_WIDTH  registered load result.
- pmmu_addr_o  out  DATA_WIDTH  latched address to the Pmmu.
- pmmu_funct3_o  out  3  latched funct3 to the Pmmu.
- pmmu_wd_o  out  DATA_WIDTH  latched store data to the Pmmu.
- pmmu_mrd_o  out  1  Pmmu read strobe, active low.
- pmmu_mwr_o  out  1  Pmmu write strobe, active low.
- pmmu_rd_i  in  DATA_WIDTH  Pmmu read data (already sign/zero-extended).
- pmmu_rdy_i  in  1  Pmmu ready, active high.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WRITE, DONE.
- IDLE:
  - on start_i, latch is_store_i, funct3_i, addr_i and wdata_i into the request register;
  - the Pmmu outputs come only from this register, never from the live inputs.
- Fault check runs combinationally on the live inputs at start. A fault is any of:
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - funct3[1:0] = 2'b11;
  - load with funct3 = 3'b110;
  - store with funct3[2] = 1.
- On a fault: IDLE→DONE with fault_o = 1; no strobe is driven.
- Load: IDLE→RD_ADDR→RD_DATA→DONE.
  - mrd low in RD_ADDR and RD_DATA.
  - pmmu_rd_i is captured into load_data_o at the edge leaving RD_DATA.
- Byte/halfword store: IDLE→RD_ADDR→RD_DATA→WRITE→DONE.
  - mrd low in RD_ADDR and RD_DATA.
  - In WRITE: mwr low, mrd high; the BRAM holds its last read word, which the Pmmu merges.
- Word store: IDLE→WRITE→DONE; no read phase.
- Ready gating: the RD_ADDR or WRITE state is entered only when pmmu_rdy_i = 1; otherwise the FSM stays in IDLE with the request latched and busy_o = 1.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- mrd and mwr are never low in the same cycle.
- load_data_o:
  - holds its value until the next successful load;
  - is unchanged by stores and faults.
- start_i while busy_o = 1 is ignored; no queueing.

## Timing
- Cycle 0 is the edge that samples start_i.
- done_o is high in the following cycle:
  - fault: cycle 1;
  - word store: cycle 2;
  - load: cycle 3;
  - byte/halfword store: cycle 4.
- load_data_o is valid in the same cycle as done_o.
- Back-to-back: a start_i in the cycle after DONE (state is IDLE) is accepted.
- Reset values (at the edge where reset_i is sampled high):
  - state = IDLE;
  - mrd = mwr = 1;
  - busy_o = done_o = fault_o = 0;
  - load_data_o and all pmmu_* data/address/funct3 outputs = 0.
- Reset mid-operation: strobes go inactive at the reset edge. An aborted RMW produces no write, and no done_o follows.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Structure
- Package mem_pkg holds:
  - BYTE_SIZE = 2'b00, HALFWORD_SIZE = 2'b01, WORD_SIZE = 2'b10;
  - the seq_state_t enum.
- Pmmu imports the same constants.
- Sub-module ls_align_check is combinational: funct3, addr[1:0] and is_store in, fault out. It is reused by the decoder for early trap detection.

## Test plan
- Preload word 0x10 = 0x80706050. LB at 0x13 → done_o in cycle 3, load_data_o = 0xFFFFFF80, fault_o = 0.
- LBU at 0x13 → 0x00000080. LH at 0x12 → 0xFFFF8070. LHU at 0x12 → 0x00008070.
- SB with data 0x000000AA at 0x11:
  - mrd low in cycles 1–2, mwr low in cycle 3 only, done_o in cycle 4;
  - a following LW at 0x10 returns 0x8070AA50.
- SW 0x12345678 at 0x12 → fault_o = done_o = 1 in cycle 1; strobes never low; memory unchanged.
- SW 0xDEADBEEF at 0x14 → done_o in cycle 2; start_i pulsed in cycle 1 is ignored; a new LW accepted in cycle 3 returns 0xDEADBEEF.
- Reset pulsed in RD_DATA of an SH → next cycle state = IDLE, strobes high, no write, no done_o; a later LW at that address returns the original word.
